// File: rtl/bsg_cgol_engine_arbiter.sv
// bsg_cgol_engine_arbiter: round-robin sharing of one Game-of-Life engine among num_req_p requesters.
// The winner owns the engine from issue through completion until its result is consumed.
module bsg_cgol_engine_arbiter #(
  parameter int num_req_p = 4,
  parameter int max_game_length_p = 1024,
  localparam int game_len_width_lp = (max_game_length_p > 1) ? $clog2(max_game_length_p) : 1,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*game_len_width_lp-1:0] req_frames_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  input  logic [num_req_p-1:0]                   resp_yumi_i,
  output logic [game_len_width_lp-1:0]           eng_frames_o,
  output logic                                   eng_v_o,
  input  logic                                   eng_ready_i,
  input  logic                                   eng_v_i,
  output logic                                   eng_yumi_o,
  output logic [id_width_lp-1:0]                 owner_o,
  output logic                                   busy_o
);
  typedef enum logic [1:0] {eIDLE, eISSUE, eRUN, eRETURN} state_e;
  state_e state, state_n;
  logic [id_width_lp-1:0] ptr_r, owner_r, grant_id;
  logic [game_len_width_lp-1:0] frames_r, grant_frames;
  logic grant_v;
  // Scan from ptr_r upward with wrap; the lowest offset with a valid request wins.
  always_comb begin
    grant_v = 1'b0;
    grant_id = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req_v_i[(int'(ptr_r) + k) % num_req_p]) begin
        grant_v = 1'b1;
        grant_id = id_width_lp'((int'(ptr_r) + k) % num_req_p);
      end
    end
    grant_frames = req_frames_i[grant_id*game_len_width_lp +: game_len_width_lp];
  end
  always_comb begin
    state_n = state;
    req_ready_o = '0;
    resp_v_o = '0;
    eng_v_o = 1'b0;
    eng_yumi_o = 1'b0;
    unique case (state)
      eIDLE: if (grant_v) begin
        req_ready_o[grant_id] = 1'b1;
        state_n = eISSUE;
      end
      eISSUE: begin
        eng_v_o = 1'b1;
        state_n = eng_ready_i ? eRUN : eISSUE;
      end
      eRUN: state_n = eng_v_i ? eRETURN : eRUN;
      eRETURN: begin
        resp_v_o[owner_r] = 1'b1;
        eng_yumi_o = resp_yumi_i[owner_r];
        state_n = resp_yumi_i[owner_r] ? eIDLE : eRETURN;
      end
      default: state_n = eIDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= eIDLE;
      ptr_r <= '0;
      owner_r <= '0;
      frames_r <= '0;
    end else begin
      state <= state_n;
      if (state == eIDLE && grant_v) begin
        owner_r <= grant_id;
        frames_r <= grant_frames;
      end
      if (state == eRETURN && resp_yumi_i[owner_r])
        ptr_r <= (owner_r == id_width_lp'(num_req_p - 1)) ? '0 : owner_r + id_width_lp'(1);
    end
  end
  assign eng_frames_o = frames_r;
  assign owner_o = owner_r;
  assign busy_o = state != eIDLE;
endmodule

// File: doc/bsg_cgol_engine_arbiter.md
# bsg_cgol_engine_arbiter

- Shares one Game-of-Life engine (control FSM plus cell array) among `num_req_p` requesters.
- Round-robin arbitration; the winner holds the grant for the whole job, from issue through engine completion to result consumption.
- Forwards the winner's frame count to the engine input channel and routes the engine's done/valid back to the owning requester.
- Sits between the host-side request ports and the engine's frames/v/ready and v/yumi channels.

## Interface
- `num_req_p`, default 4: number of requesters, ≥2; need not be a power of two.
- `max_game_length_p`, default 1024: engine frame limit.
  - `game_len_width_lp` = `BSG_SAFE_CLOG2(max_game_length_p)` (localparam).
  - `id_width_lp` = `BSG_SAFE_CLOG2(num_req_p)` (localparam).
- `clk_i` in 1: single clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `req_v_i` in `num_req_p`: per-requester job valid.
- `req_frames_i` in `num_req_p*game_len_width_lp`: per-requester frame count; slice i = bits [i*W +: W].
- `req_ready_o` out `num_req_p`: per-requester accept, one-hot or zero.
- `resp_v_o` out `num_req_p`: per-requester result valid, one-hot or zero.
- `resp_yumi_i` in `num_req_p`: per-requester result consumed.
- `eng_frames_o` out `game_len_width_lp`: frame count to the engine.
- `eng_v_o` out 1: job valid to the engine.
- `eng_ready_i` in 1: engine ready.
- `eng_v_i` in 1: engine done (result valid).
- `eng_yumi_o` out 1: result consumed, to the engine.
- `owner_o` out `id_width_lp`: current or last grant holder.
- `busy_o` out 1: high in any state other than eIDLE.

## Operation
- State machine: eIDLE → eISSUE → eRUN → eRETURN → eIDLE.
- Registers: `state`, `ptr_r` (round-robin priority pointer), `owner_r`, `frames_r`.
- **eIDLE**
  - Winner = first i with `req_v_i[i]`, searching `ptr_r`, `ptr_r+1`, … with modulo `num_req_p` wrap.
  - `req_ready_o[winner]` = 1; all other bits 0. This is combinational from `req_v_i`.
  - On a winner: latch `owner_r` ← winner and `frames_r` ← slice(winner), then go to eISSUE.
  - No valid requests: stay in eIDLE; `req_ready_o` = 0.
- **eISSUE**
  - `eng_v_o` = 1.
  - Go to eRUN on `eng_ready_i`; otherwise hold.
- **eRUN**
  - All handshake outputs 0.
  - Go to eRETURN on `eng_v_i`.
- **eRETURN**
  - `resp_v_o[owner_r]` = 1.
  - `eng_yumi_o` = `resp_yumi_i[owner_r]`.
  - On that yumi: `ptr_r` ← `owner_r`+1, wrapping `num_req_p-1` → 0; go to eIDLE.
- `eng_frames_o` = `frames_r` at all times, so it is stable from eISSUE through eRETURN. The engine compares against it continuously.
- Frame counts are forwarded unchanged, with no clamping; 0 is legal.
- `resp_yumi_i` bits for non-owners are ignored, as are `eng_v_i` outside eRUN and `eng_ready_i` outside eISSUE.
- `owner_o` = `owner_r`.
- Requesters follow valid/ready: hold `req_v_i` and frames until accepted. Losers stay pending and are not dropped.

## Timing
- Reset (`reset_n_i` low, asynchronous): state eIDLE, `ptr_r` = 0, `owner_r` = 0, `frames_r` = 0. Resulting outputs:
  - `eng_v_o`, `eng_yumi_o`, `resp_v_o`, `busy_o` = 0.
  - `owner_o` = 0, `eng_frames_o` = 0.
  - `req_ready_o` follows eIDLE arbitration with ptr = 0.
- Reset deassertion is synchronised by the surrounding reset logic.
- Reset mid-job, in any state: immediate return to eIDLE and the job is lost. The engine must be reset concurrently.
- Accept at edge t puts `eng_v_o` high in cycle t+1. Earliest engine handshake is at t+1.
- `eng_v_i` sampled at edge u puts `resp_v_o` high from cycle u+1 until yumi.
- Consumption at edge y allows a new acceptance in cycle y+1. Minimum turnaround between jobs is 1 cycle in eIDLE.
- Simultaneous requests: exactly one is granted per job, in round-robin order from `ptr_r`.
- Grant holder ownership is locked for the whole job. No preemption.

## Test plan
- **Single job:** reset, then `req_v_i` = 0b0100 with frames 5 and the engine model ready.
  - `req_ready_o` = 0b0100.
  - `eng_v_o` rises next cycle with `eng_frames_o` = 5.
  - After `eng_v_i`, `resp_v_o` = 0b0100.
  - Yumi returns to eIDLE with `ptr_r` = 3.
- **Fairness:** all 4 requesters hold valid for 8 jobs.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `owner_o` matches each grant.
- **Wrap, non-power-of-two:** `num_req_p` = 3, ptr at 2, `req_v_i` = 0b011.
  - Grant 0, then 1.
- **Backpressure:** `eng_ready_i` low for 10 cycles in eISSUE.
  - `eng_v_o` and `eng_frames_o` stay stable.
  - `req_ready_o` = 0 throughout.
- **Delayed and stray yumi:** in eRETURN, pulse `resp_yumi_i` on a non-owner, then assert the owner's yumi 7 cycles later.
  - The stray yumi is ignored.
  - `eng_yumi_o` pulses once, coincident with the owner's yumi.
- **Async reset in eRUN:** drop `reset_n_i` mid-clock.
  - Outputs reach their reset values before the next edge.
  - `busy_o` = 0 and `ptr_r` = 0.
  - After release, a new request is accepted normally.
